// File: rtl/banked_sync_ram_2p.sv
// Dual-port banked synchronous RAM with valid/ready handshake, round-robin
// arbitration on same-bank collisions and a saturating conflict counter.
module banked_sync_ram_2p #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int BANK_BITS  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_cs,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ready,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_cs,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ready,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_rvalid,
  output logic [CNT_WIDTH-1:0]  conflict_count
);
  localparam int NUM_BANKS  = 1 << BANK_BITS;
  localparam int IDX_W      = ADDR_WIDTH - BANK_BITS;
  localparam int BANK_DEPTH = 1 << IDX_W;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [BANK_BITS-1:0] a_bank, b_bank;
  logic [IDX_W-1:0]     a_idx, b_idx;
  logic                 conflict_p0;
  logic                 ptr_b;
  logic                 live_p0;
  logic                 a_acc_p0, b_acc_p0;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_q;

  assign a_bank = a_addr[ADDR_WIDTH-1 -: BANK_BITS];
  assign b_bank = b_addr[ADDR_WIDTH-1 -: BANK_BITS];
  assign a_idx  = a_addr[IDX_W-1:0];
  assign b_idx  = b_addr[IDX_W-1:0];

  // ptr_b = 1 means port B currently wins a same-bank collision
  assign conflict_p0 = a_cs && b_cs && (a_bank == b_bank);
  assign a_ready     = !conflict_p0 || !ptr_b;
  assign b_ready     = !conflict_p0 || ptr_b;
  assign live_p0     = !rst;
  assign a_acc_p0    = a_cs && a_ready && live_p0;
  assign b_acc_p0    = b_cs && b_ready && live_p0;

  // Stage p0: each bank serves at most one port, so a simple 2:1 mux suffices
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [DATA_WIDTH-1:0] store [BANK_DEPTH];
    logic                  sel_a, sel_b, we;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] wd;

    assign sel_a = a_acc_p0 && (a_bank == BANK_BITS'(g));
    assign sel_b = b_acc_p0 && (b_bank == BANK_BITS'(g));
    assign we    = (sel_a && a_we) || (sel_b && b_we);
    assign idx   = sel_a ? a_idx : b_idx;
    assign wd    = sel_a ? a_wdata : b_wdata;

    always_ff @(posedge clk) begin
      if (we) store[idx] <= wd;
    end

    assign bank_q[g] = store[idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_b          <= 1'b0;
      conflict_count <= '0;
    end else if (conflict_p0) begin
      ptr_b          <= ~ptr_b;
      conflict_count <= sat_inc(conflict_count);
    end
  end

  // Stage p1: per-port read registers; rdata holds when no read was accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_acc_p0 && !a_we;
      b_rvalid <= b_acc_p0 && !b_we;
      if (a_acc_p0 && !a_we) a_rdata <= bank_q[a_bank];
      if (b_acc_p0 && !b_we) b_rdata <= bank_q[b_bank];
    end
  end

endmodule

// File: tb/tb_banked_sync_ram_2p.sv
// Scoreboard bench for banked_sync_ram_2p: a reference memory, pointer and
// counter predict ready/rvalid/rdata/conflict_count every cycle.
module tb_banked_sync_ram_2p;
  localparam int AW = 8, DW = 8, BB = 2, CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_cs, a_we, b_cs, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic          a_ready, b_ready, a_rvalid, b_rvalid;
  logic [CW-1:0] conflict_count;

  always #5 clk = ~clk;

  banked_sync_ram_2p #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_BITS(BB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .a_cs(a_cs), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_cs(b_cs), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .conflict_count(conflict_count)
  );

  int            checks = 0, failures = 0;
  int            nrv_a, nrv_b;
  logic [DW-1:0] mem_m [256];
  logic          ptr_m;
  logic [CW-1:0] cnt_m;
  logic [DW-1:0] last_a, last_b;
  logic [DW-1:0] qa[$], qb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    ptr_m = 1'b0; cnt_m = '0; last_a = '0; last_b = '0;
    qa.delete(); qb.delete();
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input logic acs, awe, input logic [7:0] aad, awd,
                      input logic bcs, bwe, input logic [7:0] bad, bwd);
    logic conf, ar, br, aacc, bacc, erva, ervb;
    a_cs = acs; a_we = awe; a_addr = aad; a_wdata = awd;
    b_cs = bcs; b_we = bwe; b_addr = bad; b_wdata = bwd;
    #1;
    conf = acs && bcs && (aad[7:6] == bad[7:6]);
    ar = !conf || !ptr_m;
    br = !conf || ptr_m;
    check("a_ready", a_ready, ar);
    check("b_ready", b_ready, br);
    aacc = acs && ar;
    bacc = bcs && br;
    if (aacc && !awe) qa.push_back(mem_m[aad]);
    if (bacc && !bwe) qb.push_back(mem_m[bad]);
    @(posedge clk);
    if (aacc && awe) mem_m[aad] = awd;
    if (bacc && bwe) mem_m[bad] = bwd;
    if (conf) begin
      ptr_m = !ptr_m;
      if (cnt_m != '1) cnt_m = cnt_m + 1'b1;
    end
    erva = aacc && !awe;
    ervb = bacc && !bwe;
    #1;
    check("a_rvalid", a_rvalid, erva);
    if (erva && qa.size() > 0) begin nrv_a++; last_a = qa.pop_front(); end
    check("a_rdata", a_rdata, last_a);
    check("b_rvalid", b_rvalid, ervb);
    if (ervb && qb.size() > 0) begin nrv_b++; last_b = qb.pop_front(); end
    check("b_rdata", b_rdata, last_b);
    check("conflict_count", conflict_count, cnt_m);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; a_cs = 1'b0; b_cs = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1;
    a_cs = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_cs = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_rvalid", a_rvalid, 0);
    check("rst_b_rvalid", b_rvalid, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_b_rdata", b_rdata, 0);
    check("rst_count", conflict_count, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single-port writes then back-to-back reads
    for (int i = 0; i < 4; i++)
      step(1, 1, 8'h3C + 8'(i), 8'h11 * 8'(i + 1), 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step(1, 0, 8'h3C + 8'(i), 0, 0, 0, 0, 0);
    check("t1_last", a_rdata, 8'h44);

    // Parallel access to banks 1 and 2
    step(1, 1, 8'h7F, 8'hA5, 1, 1, 8'hBF, 8'h5A);
    step(1, 0, 8'hBF, 0, 1, 0, 8'h7F, 0);
    check("t2_a_rdata", a_rdata, 8'h5A);
    check("t2_b_rdata", b_rdata, 8'hA5);

    // Sustained bank-3 conflict
    step(1, 1, 8'hC0, 8'h66, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 8'hC1, 8'h77);
    nrv_a = 0; nrv_b = 0;
    for (int i = 0; i < 6; i++)
      step(1, 0, 8'hC0, 0, 1, 0, 8'hC1, 0);
    check("t3_rv_a", nrv_a, 3);
    check("t3_rv_b", nrv_b, 3);
    check("t3_count", conflict_count, 6);

    // Same-address write/read collision, B serialised after A
    step(1, 1, 8'h10, 8'h99, 1, 0, 8'h10, 0);
    step(0, 0, 0, 0, 1, 0, 8'h10, 0);
    check("t4_b_rdata", b_rdata, 8'h99);

    // Counter saturation
    do_reset();
    for (int i = 0; i < 20; i++)
      step(1, 0, 8'hC0, 0, 1, 0, 8'hC1, 0);
    check("t5_sat", conflict_count, 15);

    // Reset in the middle of traffic
    step(0, 0, 0, 0, 1, 1, 8'h20, 8'h55);
    step(1, 0, 8'h3C, 0, 1, 0, 8'h00, 0);
    rst = 1'b1;
    a_cs = 1'b0;
    b_cs = 1'b1; b_we = 1'b1; b_addr = 8'h20; b_wdata = 8'hEE;
    #1;
    check("t6_rvalid_drop", a_rvalid, 0);
    check("t6_rdata_clr", a_rdata, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1, 0, 8'h3C, 0, 1, 0, 8'h20, 0);
    check("t6_3c", a_rdata, 8'h11);
    step(0, 0, 0, 0, 1, 0, 8'h20, 0);
    check("t6_20", b_rdata, 8'h55);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
